idecode_sb: RTL and testbench

IDECODE_SB -- requirements
Module: idecode_sb

---
 rtl/idecode_sb.sv | 113 +++++++++++
 tb/tb_idecode_sb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/idecode_sb.sv
// Instruction decode stage with a register scoreboard for RAW/WAW hazard stalls.
// Define IDECODE_SB_FWD_EN to let a same-cycle writeback bypass a busy register.
module idecode_sb #(
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_OPC  = 4,
  parameter int unsigned W_REG  = 3,
  parameter int unsigned W_IMM  = 8,
  parameter int unsigned W_INST = W_OPC + 1 + 2 * W_REG + W_IMM,
  parameter logic [2**W_OPC-1:0] WB_MASK   = '1,
  parameter logic [2**W_OPC-1:0] SEXT_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [W_INST-1:0] inst_i,
  input  logic [W_ADDR-1:0] origaddr_i,
  output logic              stall_o,
  output logic              v_o,
  input  logic              stall_i,
  output logic [W_DATA-1:0] src_o,
  output logic [W_DATA-1:0] dest_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic              wb_o,
  output logic [W_REG-1:0]  rd_num_o,
  output logic [W_ADDR-1:0] origaddr_o,
  output logic [W_REG-1:0]  r0_num_o,
  output logic [W_REG-1:0]  r1_num_o,
  input  logic [W_DATA-1:0] r0_data_i,
  input  logic [W_DATA-1:0] r1_data_i,
  input  logic              wb_v_i,
  input  logic [W_REG-1:0]  wb_num_i,
  input  logic [W_DATA-1:0] wb_data_i
);

  localparam int unsigned NREG = 2 ** W_REG;

  logic [W_OPC-1:0] opc;
  logic             immf;
  logic [W_REG-1:0] rd;
  logic [W_REG-1:0] rs;
  logic [W_IMM-1:0] imm;

  assign {opc, immf, rd, rs, imm} = inst_i;
  assign r0_num_o = rd;
  assign r1_num_o = rs;

  logic [NREG-1:0] busy_q, busy_d;
  logic            busy_rd, busy_rs;
  logic [W_DATA-1:0] rd_data, rs_data, imm_ext;

`ifdef IDECODE_SB_FWD_EN
  logic fwd_rd, fwd_rs;
  assign fwd_rd  = wb_v_i && (wb_num_i == rd);
  assign fwd_rs  = wb_v_i && (wb_num_i == rs);
  // A retiring writer no longer blocks; its data is bypassed straight in.
  assign busy_rd = busy_q[rd] & ~fwd_rd;
  assign busy_rs = busy_q[rs] & ~fwd_rs;
  assign rd_data = fwd_rd ? wb_data_i : r0_data_i;
  assign rs_data = fwd_rs ? wb_data_i : r1_data_i;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_i;
  assign busy_rd = busy_q[rd];
  assign busy_rs = busy_q[rs];
  assign rd_data = r0_data_i;
  assign rs_data = r1_data_i;
`endif

  assign imm_ext = SEXT_MASK[opc] ? {{(W_DATA - W_IMM){imm[W_IMM-1]}}, imm}
                                  : {{(W_DATA - W_IMM){1'b0}}, imm};

  logic hazard, free, load;

  assign hazard  = v_i & (busy_rd | (~immf & busy_rs));
  assign free    = ~v_o | ~stall_i;
  assign load    = free & v_i & ~hazard;
  assign stall_o = (v_o & stall_i) | (v_i & hazard);

  always_comb begin
    busy_d = busy_q;
    if (wb_v_i) busy_d[wb_num_i] = 1'b0;
    // Set after clear so a same-edge issue to the retiring register stays busy.
    if (load && WB_MASK[opc]) busy_d[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      v_o        <= 1'b0;
      src_o      <= '0;
      dest_o     <= '0;
      opc_o      <= '0;
      wb_o       <= 1'b0;
      rd_num_o   <= '0;
      origaddr_o <= '0;
    end else begin
      busy_q <= busy_d;
      if (free) begin
        v_o <= load;
        if (load) begin
          src_o      <= immf ? imm_ext : rs_data;
          dest_o     <= rd_data;
          opc_o      <= opc;
          wb_o       <= WB_MASK[opc];
          rd_num_o   <= rd;
          origaddr_o <= origaddr_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_idecode_sb.sv
// Directed self-checking bench for idecode_sb: issue, scoreboard stalls, immediates,
// downstream hold, set/clear collision and asynchronous reset mid-stall.
module tb_idecode_sb;

  localparam int unsigned W_INST = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic              v_i;
  logic [W_INST-1:0] inst_i;
  logic [31:0]       origaddr_i;
  logic              stall_o;
  logic              v_o;
  logic              stall_i;
  logic [31:0]       src_o, dest_o;
  logic [3:0]        opc_o;
  logic              wb_o;
  logic [2:0]        rd_num_o;
  logic [31:0]       origaddr_o;
  logic [2:0]        r0_num_o, r1_num_o;
  logic [31:0]       r0_data_i, r1_data_i;
  logic              wb_v_i;
  logic [2:0]        wb_num_i;
  logic [31:0]       wb_data_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Register-file model: distinct recognisable value per register.
  function automatic logic [31:0] rf(input logic [2:0] n);
    return 32'h1000_0000 + 32'h11 * {29'd0, n};
  endfunction

  function automatic logic [W_INST-1:0] mk(input logic [3:0] opc, input logic immf,
                                           input logic [2:0] rd, input logic [2:0] rs,
                                           input logic [7:0] imm);
    return {opc, immf, rd, rs, imm};
  endfunction

  assign r0_data_i = rf(r0_num_o);
  assign r1_data_i = rf(r1_num_o);

  idecode_sb #(
    .WB_MASK  (16'hFF7F),
    .SEXT_MASK(16'h0004)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .v_i       (v_i),
    .inst_i    (inst_i),
    .origaddr_i(origaddr_i),
    .stall_o   (stall_o),
    .v_o       (v_o),
    .stall_i   (stall_i),
    .src_o     (src_o),
    .dest_o    (dest_o),
    .opc_o     (opc_o),
    .wb_o      (wb_o),
    .rd_num_o  (rd_num_o),
    .origaddr_o(origaddr_o),
    .r0_num_o  (r0_num_o),
    .r1_num_o  (r1_num_o),
    .r0_data_i (r0_data_i),
    .r1_data_i (r1_data_i),
    .wb_v_i    (wb_v_i),
    .wb_num_i  (wb_num_i),
    .wb_data_i (wb_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; v_i = 1'b0; inst_i = '0; origaddr_i = '0; stall_i = 1'b0;
    wb_v_i = 1'b0; wb_num_i = '0; wb_data_i = '0;
    #12;
    chk("rst_v_o", {31'd0, v_o}, 32'd0);
    chk("rst_src", src_o, 32'd0);
    chk("rst_addr", origaddr_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    rst = 1'b1;

    // Plain issue: add r1,r2.
    v_i = 1'b1; inst_i = mk(4'd0, 1'b0, 3'd1, 3'd2, 8'd0); origaddr_i = 32'h100;
    #1;
    chk("a_stall", {31'd0, stall_o}, 32'd0);
    chk("a_r0num", {29'd0, r0_num_o}, 32'd1);
    chk("a_r1num", {29'd0, r1_num_o}, 32'd2);
    tick();
    chk("a_v_o", {31'd0, v_o}, 32'd1);
    chk("a_src", src_o, rf(3'd2));
    chk("a_dest", dest_o, rf(3'd1));
    chk("a_rd", {29'd0, rd_num_o}, 32'd1);
    chk("a_wb", {31'd0, wb_o}, 32'd1);
    chk("a_addr", origaddr_o, 32'h100);

    // RAW on r1: must stall until r1 retires.
    inst_i = mk(4'd1, 1'b0, 3'd4, 3'd1, 8'd0); origaddr_i = 32'h104;
    #1;
    chk("b_stall0", {31'd0, stall_o}, 32'd1);
    tick();
    chk("b_bubble", {31'd0, v_o}, 32'd0);
    chk("b_stall1", {31'd0, stall_o}, 32'd1);
    wb_v_i = 1'b1; wb_num_i = 3'd1; wb_data_i = 32'h1234;
    #1;
`ifdef IDECODE_SB_FWD_EN
    chk("b_fwd_stall", {31'd0, stall_o}, 32'd0);
    tick();
    wb_v_i = 1'b0;
    chk("b_fwd_v_o", {31'd0, v_o}, 32'd1);
    chk("b_fwd_src", src_o, 32'h1234);
`else
    chk("b_wb_stall", {31'd0, stall_o}, 32'd1);
    tick();
    wb_v_i = 1'b0;
    chk("b_wb_bubble", {31'd0, v_o}, 32'd0);
    #1;
    chk("b_free_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("b_v_o", {31'd0, v_o}, 32'd1);
    chk("b_src", src_o, rf(3'd1));
`endif
    chk("b_rd", {29'd0, rd_num_o}, 32'd4);
    chk("b_addr", origaddr_o, 32'h104);

    // Immediates: r4 is busy but immf ignores rs.
    inst_i = mk(4'd2, 1'b1, 3'd5, 3'd4, 8'h80);
    #1;
    chk("c_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("c_sext", src_o, 32'hFFFF_FF80);
    inst_i = mk(4'd3, 1'b1, 3'd6, 3'd4, 8'h80);
    tick();
    chk("c_zext", src_o, 32'h0000_0080);
    chk("c_opc", {28'd0, opc_o}, 32'd3);

    // Downstream hold for three cycles while a new instruction waits.
    stall_i = 1'b1; inst_i = mk(4'd7, 1'b0, 3'd7, 3'd0, 8'd0); origaddr_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("d_stall_o", {31'd0, stall_o}, 32'd1);
      tick();
      chk("d_v_o", {31'd0, v_o}, 32'd1);
      chk("d_src", src_o, 32'h0000_0080);
      chk("d_opc", {28'd0, opc_o}, 32'd3);
    end
    stall_i = 1'b0;
    #1;
    chk("d_release", {31'd0, stall_o}, 32'd0);
    tick();
    chk("d_opc7", {28'd0, opc_o}, 32'd7);
    chk("d_wb7", {31'd0, wb_o}, 32'd0);
    chk("d_dest", dest_o, rf(3'd7));

    // opc 7 has no writeback, so r7 must not have become busy.
    inst_i = mk(4'd0, 1'b0, 3'd0, 3'd7, 8'd0);
    #1;
    chk("d_r7_free", {31'd0, stall_o}, 32'd0);

    // Issue rd=3 on the same edge as a retire of r3: r3 must end up busy.
    inst_i = mk(4'd0, 1'b1, 3'd3, 3'd0, 8'h05); origaddr_i = 32'h300;
    wb_v_i = 1'b1; wb_num_i = 3'd3; wb_data_i = 32'hDEAD;
    tick();
    wb_v_i = 1'b0;
    chk("e_v_o", {31'd0, v_o}, 32'd1);
    chk("e_src", src_o, 32'h5);
    inst_i = mk(4'd0, 1'b0, 3'd0, 3'd3, 8'd0); origaddr_i = 32'h304;
    #1;
    chk("e_r3_busy", {31'd0, stall_o}, 32'd1);

    // Asynchronous reset while held downstream.
    stall_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("f_v_o", {31'd0, v_o}, 32'd0);
    chk("f_busy_clr", {31'd0, stall_o}, 32'd0);
    chk("f_src", src_o, 32'd0);
    chk("f_addr", origaddr_o, 32'd0);
    #1;
    rst = 1'b1; stall_i = 1'b0;
    tick();
    chk("f_accept", {31'd0, v_o}, 32'd1);
    chk("f_src2", src_o, rf(3'd3));
    chk("f_addr2", origaddr_o, 32'h304);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
